alpaca_rescale: RTL and testbench

- Output stage directly downstream of the alpaca butterfly datapath.
- Consumes wide arith_pkt_t beats (PHASE_WIDTH+WIDTH+1 bits per re/im) on an AXI-stream-style handshake.
- Applies a run-time right shift with round-half-up and saturates each component back to WIDTH bits, emitting cx_pkt_t beats.
- Flags each frame that saturated and keeps a saturating count of such frames.

---
 rtl/alpaca_constants_pkg.sv | 6 +
 rtl/alpaca_dtypes_pkg.sv | 47 ++++
 rtl/alpaca_sat_round.sv | 23 ++
 rtl/alpaca_rescale.sv | 116 +++++++++++
 tb/tb_alpaca_rescale.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alpaca_constants_pkg.sv
// Shared sizing constants for the alpaca datapath.
package alpaca_constants_pkg;
  localparam int WIDTH        = 16;
  localparam int PHASE_WIDTH  = 16;
  localparam int SAMP_PER_CLK = 2;
endpackage

// File: rtl/alpaca_dtypes_pkg.sv
// Sample and packet types for the alpaca datapath, plus the output saturation helper.
package alpaca_dtypes_pkg;
  import alpaca_constants_pkg::*;

  localparam int AW = PHASE_WIDTH + WIDTH + 1;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cx_t;
  typedef cx_t [SAMP_PER_CLK-1:0] cx_pkt_t;

  typedef struct packed {
    logic signed [AW-1:0] re;
    logic signed [AW-1:0] im;
  } arith_t;
  typedef arith_t [SAMP_PER_CLK-1:0] arith_pkt_t;

  typedef struct packed {
    logic signed [AW:0] re;
    logic signed [AW:0] im;
  } rnd_t;
  typedef rnd_t [SAMP_PER_CLK-1:0] rnd_pkt_t;

  typedef struct packed {
    logic                    sat;
    logic signed [WIDTH-1:0] val;
  } sat_t;

  localparam logic signed [AW:0] SAT_MAX = (AW+1)'((2 ** (WIDTH-1)) - 1);
  localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

  // Clip a rounded value into WIDTH bits and report whether clipping happened.
  function automatic sat_t saturate(input logic signed [AW:0] y);
    sat_t r;
    r.sat = 1'b0;
    r.val = y[WIDTH-1:0];
    if (y > SAT_MAX) begin
      r.sat = 1'b1;
      r.val = SAT_MAX[WIDTH-1:0];
    end else if (y < SAT_MIN) begin
      r.sat = 1'b1;
      r.val = SAT_MIN[WIDTH-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/alpaca_sat_round.sv
// Per-component round-half-up arithmetic right shift, one bit wider than the input so
// the rounding bias can never wrap.
module alpaca_sat_round
  import alpaca_constants_pkg::*;
  import alpaca_dtypes_pkg::*;
#(
  parameter int SHIFT_W = 6
) (
  input  logic signed [AW-1:0]    x,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [AW:0]      y
);
  logic signed [AW:0] xe;
  logic signed [AW:0] bias;

  // NOTE: every variable written here gets a default first, so no path leaves a latch.
  always_comb begin
    xe   = x;
    bias = '0;
    if (shift != '0) bias = (AW+1)'(1) <<< (shift - SHIFT_W'(1));
    y = (xe + bias) >>> shift;
  end
endmodule

// File: rtl/alpaca_rescale.sv
// Output stage after the butterfly: two-stage elastic pipeline that rescales, saturates
// and flags saturated frames, with a saturating count of flagged frames.
module alpaca_rescale
  import alpaca_constants_pkg::*;
  import alpaca_dtypes_pkg::*;
#(
  parameter int SHIFT_W   = 6,
  parameter int OVF_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  arith_pkt_t           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  input  logic [SHIFT_W-1:0]   shift_i,
  output cx_pkt_t              m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 m_axis_tready,
  input  logic                 cnt_clr_i,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o
);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(AW);

  logic               v1, v2, adv1, adv2, accept;
  logic               frame_start, sticky;
  logic [SHIFT_W-1:0] shift_q, shift_in, shift_use;
  rnd_pkt_t           rnd_d, s1_data;
  logic               s1_last;
  cx_pkt_t            sat_d;
  logic               beat_sat;
  sat_t               sr, si;

  assign adv2          = ~v2 | m_axis_tready;
  assign adv1          = ~v1 | adv2;
  assign s_axis_tready = adv1;
  assign accept        = s_axis_tvalid & adv1;
  assign m_axis_tvalid = v2;

  // The first beat of a frame uses the live shift and latches it for the rest of the frame.
  assign shift_in  = (shift_i > SHIFT_MAX) ? SHIFT_MAX : shift_i;
  assign shift_use = frame_start ? shift_in : shift_q;

  for (genvar i = 0; i < SAMP_PER_CLK; i++) begin : g_rnd
    alpaca_sat_round #(.SHIFT_W(SHIFT_W)) u_re (
      .x(s_axis_tdata[i].re), .shift(shift_use), .y(rnd_d[i].re)
    );
    alpaca_sat_round #(.SHIFT_W(SHIFT_W)) u_im (
      .x(s_axis_tdata[i].im), .shift(shift_use), .y(rnd_d[i].im)
    );
  end

  always_comb begin
    sat_d    = '0;
    beat_sat = 1'b0;
    sr       = '0;
    si       = '0;
    for (int i = 0; i < SAMP_PER_CLK; i++) begin
      sr          = saturate(s1_data[i].re);
      si          = saturate(s1_data[i].im);
      sat_d[i].re = sr.val;
      sat_d[i].im = si.val;
      beat_sat    = beat_sat | sr.sat | si.sat;
    end
  end

  // NOTE: registers update with <= so each one samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      s1_data     <= '0;
      s1_last     <= 1'b0;
      frame_start <= 1'b1;
      shift_q     <= '0;
    end else if (adv1) begin
      v1 <= s_axis_tvalid;
      if (accept) begin
        s1_data     <= rnd_d;
        s1_last     <= s_axis_tlast;
        frame_start <= s_axis_tlast;
        if (frame_start) shift_q <= shift_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2           <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
      sticky       <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        m_axis_tdata <= sat_d;
        m_axis_tlast <= s1_last;
        m_axis_tuser <= s1_last & (sticky | beat_sat);
        sticky       <= ~s1_last & (sticky | beat_sat);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      ovf_cnt_o <= '0;
    end else if (m_axis_tvalid & m_axis_tready & m_axis_tlast & m_axis_tuser &
                 (ovf_cnt_o != '1)) begin
      ovf_cnt_o <= ovf_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_alpaca_rescale.sv
// Self-checking bench for alpaca_rescale: directed scenarios plus random traffic,
// scored against an arithmetic reference model of the rescale rules.
module tb_alpaca_rescale;
  import alpaca_constants_pkg::*;
  import alpaca_dtypes_pkg::*;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic             clk, rst;
  arith_pkt_t       s_axis_tdata;
  logic             s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [5:0]       shift_i;
  cx_pkt_t          m_axis_tdata;
  logic             m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
  logic             cnt_clr_i;
  logic [CNT_W-1:0] ovf_cnt_o;

  alpaca_rescale #(.SHIFT_W(6), .OVF_CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .shift_i(shift_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .cnt_clr_i(cnt_clr_i), .ovf_cnt_o(ovf_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // Reference model: expected beats queued at acceptance, popped at output handshake.
  typedef struct {
    cx_pkt_t d;
    logic    last;
    logic    user;
    int      acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e, push_e;
  bit   m_fs   = 1'b1;
  bit   m_fsat = 1'b0;
  int   m_shift = 0;
  int   m_cnt  = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;

  function automatic longint ref_round(input longint x, input int s);
    longint p, n, q;
    if (s == 0) return x;
    p = longint'(1) << s;
    n = x + p / 2;
    q = n / p;
    if ((n % p != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint ref_clip(input longint y, output bit sat);
    longint lim;
    lim = longint'(1) << (WIDTH - 1);
    sat = 1'b0;
    if (y > lim - 1) begin sat = 1'b1; return lim - 1; end
    if (y < -lim)    begin sat = 1'b1; return -lim;    end
    return y;
  endfunction

  function automatic logic signed [WIDTH-1:0] ref_comp(input longint x, input int s,
                                                         inout bit any_sat);
    bit     sat;
    longint yc;
    yc = ref_clip(ref_round(x, s), sat);
    any_sat = any_sat | sat;
    return WIDTH'(yc);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_fs   = 1'b1;
      m_fsat = 1'b0;
      m_cnt  = 0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 128'(exp_q.size()), 128'(1));
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
                {mon_e.d, mon_e.last, mon_e.user});
          if (lat_chk) check("latency", 128'(cyc - mon_e.acc), 128'(2));
          if (mon_e.last && mon_e.user && m_cnt < CNT_MAX) m_cnt++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        bit bs;
        int s;
        bs = 1'b0;
        s  = m_fs ? ((int'(shift_i) > AW) ? AW : int'(shift_i)) : m_shift;
        if (m_fs) m_shift = s;
        for (int i = 0; i < SAMP_PER_CLK; i++) begin
          push_e.d[i].re = ref_comp(longint'(s_axis_tdata[i].re), s, bs);
          push_e.d[i].im = ref_comp(longint'(s_axis_tdata[i].im), s, bs);
        end
        push_e.last = s_axis_tlast;
        push_e.user = s_axis_tlast ? (m_fsat | bs) : 1'b0;
        m_fsat      = s_axis_tlast ? 1'b0 : (m_fsat | bs);
        m_fs        = s_axis_tlast;
        push_e.acc  = cyc;
        exp_q.push_back(push_e);
      end
    end
  end

  function automatic arith_pkt_t mk(input longint r0, input longint i0,
                                    input longint r1, input longint i1);
    arith_pkt_t p;
    p[0].re = AW'(r0); p[0].im = AW'(i0);
    p[1].re = AW'(r1); p[1].im = AW'(i1);
    return p;
  endfunction

  function automatic logic signed [AW-1:0] rand_comp();
    case ($urandom_range(0, 2))
      0:       return AW'({$urandom, $urandom});
      1:       return AW'(longint'($urandom_range(0, 140000)) - 70000);
      default: return AW'(longint'($urandom_range(0, 16)) + 32760);
    endcase
  endfunction

  // Stimulus tasks all return just after a rising edge.
  task automatic send(input arith_pkt_t d, input logic last);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("send_timeout", 128'(n), 128'(0));
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 200) begin @(negedge clk); n++; end
    check("drain", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    arith_pkt_t m256, msat, held;
    int         idx, n, sent;
    bit         acc, pending;

    rst = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    shift_i = '0; m_axis_tready = 1'b1; cnt_clr_i = 1'b0;
    m256 = mk(256, 256, 256, 256);
    msat = mk(40000, -40000, 40000, -40000);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tuser", m_axis_tuser, 1'b0);
    check("rst_cnt", ovf_cnt_o, '0);
    check("rst_tready", s_axis_tready, 1'b1);

    // Rounding at shift 16, latency with no backpressure.
    shift_i = 6'd16;
    lat_chk = 1'b1;
    send(mk(32768, 196608, -32768, -98304), 1'b1);
    send(mk(1000, -1000, 65535, -65537), 1'b1);
    drain();
    lat_chk = 1'b0;

    // Saturation and frame flag.
    shift_i = 6'd0;
    send(msat, 1'b1);
    drain();
    check("sat_cnt", ovf_cnt_o, 2'd1);
    send(mk(5, -5, 7, -7), 1'b1);
    drain();
    check("clean_cnt", ovf_cnt_o, 2'd1);

    // Backpressure with a stall on cycles 3..6.
    idx = 0;
    held = '0;
    for (int c = 0; c < 40 && (idx < 8 || c < 12); c++) begin
      m_axis_tready = !(c >= 3 && c <= 6);
      if (idx < 8) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = mk(idx, -idx, idx, -idx);
        s_axis_tlast  = (idx == 7);
      end else begin
        s_axis_tvalid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        check("bp_tready_low", s_axis_tready, 1'b0);
        check("bp_tvalid", m_axis_tvalid, 1'b1);
      end
      if (c == 3) held = m_axis_tdata;
      if (c >= 4 && c <= 6) check("bp_stable", m_axis_tdata, held);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    check("bp_sent", 128'(idx), 128'(8));
    drain();

    // Shift latched per frame; oversize shift clamps.
    shift_i = 6'd4;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) shift_i = 6'd8;
      send(m256, b == 3);
    end
    for (int b = 0; b < 4; b++) send(m256, b == 3);
    shift_i = 6'd63;
    send(m256, 1'b1);
    drain();

    // Asynchronous reset with both stages occupied.
    shift_i = 6'd4;
    send(m256, 1'b0);
    send(m256, 1'b0);
    check("pre_rst_valid", m_axis_tvalid, 1'b1);
    check("pre_rst_cnt", ovf_cnt_o, 2'd1);
    #2 rst = 1'b1;
    #1;
    check("async_tvalid", m_axis_tvalid, 1'b0);
    check("async_cnt", ovf_cnt_o, '0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    shift_i = 6'd8;
    send(m256, 1'b1);
    drain();

    // Saturating counter and clear priority.
    shift_i = 6'd0;
    repeat (5) send(msat, 1'b1);
    drain();
    check("cnt_hold", ovf_cnt_o, 2'd3);
    send(msat, 1'b1);
    n = 0;
    @(negedge clk);
    while (!(m_axis_tvalid && m_axis_tready) && n < 20) begin @(negedge clk); n++; end
    #1 cnt_clr_i = 1'b1;
    @(posedge clk); #1 cnt_clr_i = 1'b0;
    m_cnt = 0;
    check("clr_wins", ovf_cnt_o, '0);
    send(msat, 1'b1);
    drain();
    check("cnt_after_clr", ovf_cnt_o, 2'd1);

    // Random traffic with random backpressure.
    sent = 0;
    pending = 1'b0;
    for (int c = 0; c < 6000 && sent < 300; c++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      shift_i = 6'($urandom_range(0, 40));
      if (!pending && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < SAMP_PER_CLK; i++) begin
          s_axis_tdata[i].re = rand_comp();
          s_axis_tdata[i].im = rand_comp();
        end
        s_axis_tlast = ($urandom_range(0, 3) == 0);
        pending = 1'b1;
      end
      s_axis_tvalid = pending;
      @(negedge clk);
      acc = pending && s_axis_tready;
      @(posedge clk); #1;
      if (acc) begin pending = 1'b0; sent++; end
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    check("rand_sent", 128'(sent), 128'(300));
    drain();
    check("rand_cnt", 128'(ovf_cnt_o), 128'(m_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
